spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
- SPI mode-0 master that originates the bridge command frames the FPGA-side SPI bridge slave decodes.
- Converts a parallel read/write request (17-bit address, 8-bit data) into a CS-framed byte sequence, waits for the remote access, and clocks the read-back byte.
- Used as the bus initiator for self-test and loopback benches, and for driving a second bridge-equipped board.

Parameters:
- SCLK_DIV, 2, sys_clk cycles per SCLK half-period; also the CS setup, hold and min-high time; minimum 1.
- XFER_WAIT, 16, sys_clk cycles between the last argument byte and the read-back byte; minimum 1.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  request strobe; accepted only when cmd_ready=1.
- cmd_ready  out  1  master idle; able to accept a request.
- cmd_rw_b  in  1  1=read, 0=write.
- cmd_addr  in  17  target address.
- cmd_data  in  8  write data.
- rd_data  out  8  read result; held until the next read completes.
- done  out  1  one-cycle pulse when a frame completes.
- spi_sclk  out  1  SPI clock; idles low.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  master-out data, MSB first.
- spi_miso  in  1  master-in data.
- state  out  3  FSM state, exposed for debug.

Behaviour:
- Reset values: cmd_ready=1, done=0, rd_data=0x00, spi_sclk=0, spi_cs_n=1, spi_mosi=0, state=IDLE, last_valid=0. Reset mid-frame aborts on the next edge; no done pulse.
- Accept: a request is accepted when cmd_start and cmd_ready are both high. cmd_rw_b, cmd_addr and cmd_data are latched, and cmd_ready=0 from the next cycle. cmd_start with cmd_ready=0 is ignored.
- Command byte: bits [7:5]=len, bits [4:1]=0, bit [0]=a16.
  - Write: len=4. Bytes 0x80|a16, data, addr[15:8], addr[7:0].
  - Read: len=3. Bytes 0x60|a16, addr[15:8], addr[7:0], then a read-back byte.
  - Sequential read (optional feature): byte 0x20, then a read-back byte.
- Read-back byte: MOSI sends 0x00; the 8 captured MISO bits load rd_data.
- FSM states: IDLE=0, SETUP=1, SHIFT=2, GAP=3, WAIT=4, HOLD=5, DONE=6.
  - IDLE: cs_n=1; go to SETUP on accept.
  - SETUP: cs_n=0, sclk=0 for SCLK_DIV cycles; MOSI is driven with the first bit.
  - SHIFT: 8 bits per byte.
    - Each bit has a low phase (SCLK_DIV cycles, MOSI stable) then a high phase (SCLK_DIV cycles).
    - MISO is sampled on the sys_clk edge that raises sclk.
    - MOSI changes only when sclk falls or at byte start.
  - GAP: after each non-final argument byte, sclk=0 for SCLK_DIV cycles, then back to SHIFT.
  - WAIT: for reads only, after the final argument byte; XFER_WAIT cycles, then SHIFT for the read-back byte.
  - HOLD: after the final byte, cs_n=0, sclk=0 for SCLK_DIV cycles.
  - DONE: cs_n=1 for SCLK_DIV cycles; done=1 on the first cycle only. rd_data is valid when done rises. Then IDLE with cmd_ready=1.
- Frame SCLK rising-edge counts: write 32, read 32, sequential read 16.
- Address tracking: on every completed frame, last_addr is set to the frame's effective address and last_valid=1.
- Sequential match: read, last_valid=1, and cmd_addr == last_addr+1 as 17-bit addition (0x1FFFF+1 wraps to 0x00000).
- Simultaneous reset and cmd_start: reset wins.

Optional Feature:
- Macro: SPI_CMD_MASTER_SEQ_EN.
- Defined: a read that matches the sequential condition sends the 1-byte command 0x20 instead of the 3-byte read.
- Undefined: every read uses the 3-byte form; last_addr and last_valid are not implemented.

Test Plan:
- Write, SCLK_DIV=2: addr 0x12345, data 0xA5 -> MOSI 0x81,0xA5,0x23,0x45; 32 SCLK rises; cs_n low throughout; one done pulse; cmd_ready low until DONE ends.
- Read: addr 0x08000; slave model returns 0x5C -> MOSI 0x60,0x80,0x00,0x00; rd_data=0x5C at done; XFER_WAIT gap measured before the 4th byte.
- Sequential read: a read of 0x08000 followed by a read of 0x08001.
  - Macro on: MOSI 0x20,0x00; 16 SCLK rises.
  - Macro off: MOSI 0x60,0x80,0x01,0x00.
  - Also with macro on: a write to 0x1FFFF followed by a read of 0x00000 -> MOSI 0x20.
- Busy: cmd_start pulsed at mid-frame -> ignored; the frame is unchanged; exactly one done.
- Reset at bit 3 of byte 2 -> next edge gives cs_n=1, sclk=0, cmd_ready=1, no done.
  - A following read of 0x00001 uses the full 3-byte command (last_valid was cleared).

Source files
------------

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 master that builds bridge command frames
// (write: 4 bytes, read: 3 bytes + read-back byte) from a parallel request.
// Optional feature macro SPI_CMD_MASTER_SEQ_EN: a read of last_addr+1 is sent
// as the 1-byte sequential-read command 0x20 followed by the read-back byte.
module spi_cmd_master #(
  parameter int unsigned SCLK_DIV  = 2,
  parameter int unsigned XFER_WAIT = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cmd_start,
  output logic        cmd_ready,
  input  logic        cmd_rw_b,
  input  logic [16:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int unsigned   CMAX      = (SCLK_DIV > XFER_WAIT) ? SCLK_DIV : XFER_WAIT;
  localparam int unsigned   CW        = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(XFER_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          phase_q, phase_d;   // 0: sclk low phase, 1: sclk high phase
  logic          rw_q, rw_d;
  logic          seq_q, seq_d;
  logic [16:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;

  logic          seq_match;
  logic [2:0]    last_arg;
  logic [2:0]    rb_idx;
  logic [7:0]    cur_byte;
  logic [7:0]    next_byte;

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic        seq,
                                            input logic        rw,
                                            input logic [16:0] addr,
                                            input logic [7:0]  data);
    logic [7:0] b;
    b = 8'h00;
    if (seq) begin
      if (idx == 3'd0) b = 8'h20;
    end else if (rw) begin
      case (idx)
        3'd0:    b = {3'd3, 4'd0, addr[16]};
        3'd1:    b = addr[15:8];
        3'd2:    b = addr[7:0];
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = {3'd4, 4'd0, addr[16]};
        3'd1:    b = data;
        3'd2:    b = addr[15:8];
        3'd3:    b = addr[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Frame layout: index of the final argument byte, the read-back byte, and byte contents.
  always_comb begin
    last_arg  = seq_q ? 3'd0 : (rw_q ? 3'd2 : 3'd3);
    rb_idx    = last_arg + 3'd1;
    cur_byte  = frame_byte(byte_q, seq_q, rw_q, addr_q, data_q);
    next_byte = frame_byte(byte_q + 3'd1, seq_q, rw_q, addr_q, data_q);
  end

  // Frame sequencer: next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    seq_d       = seq_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        cs_n_d      = 1'b1;
        sclk_d      = 1'b0;
        if (cmd_start && cmd_ready_q) begin
          state_d     = ST_SETUP;
          cnt_d       = '0;
          bit_d       = '0;
          byte_d      = '0;
          phase_d     = 1'b0;
          rw_d        = cmd_rw_b;
          seq_d       = seq_match;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          cmd_ready_d = 1'b0;
          cs_n_d      = 1'b0;
          // Command-byte MSB is 1 only for writes (0x8x); both read forms start with 0.
          mosi_d      = ~cmd_rw_b;
        end
      end

      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            rx_d    = {rx_q[6:0], spi_miso};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d  = bit_q + 3'd1;
              mosi_d = cur_byte[3'd6 - bit_q];
            end else begin
              bit_d  = '0;
              byte_d = byte_q + 3'd1;
              if (rw_q && (byte_q == rb_idx)) begin
                rd_data_d = rx_q;
                mosi_d    = 1'b0;
                state_d   = ST_HOLD;
              end else if (byte_q == last_arg) begin
                mosi_d  = 1'b0;
                state_d = rw_q ? ST_WAIT : ST_HOLD;
              end else begin
                mosi_d  = next_byte[7];
                state_d = ST_GAP;
              end
            end
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        if (cnt_q == DIV_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cmd_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        cmd_ready_d = 1'b1;
        cs_n_d      = 1'b1;
        sclk_d      = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
      seq_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      seq_q       <= seq_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
    end
  end

`ifdef SPI_CMD_MASTER_SEQ_EN
  logic [16:0] last_addr_q, last_addr_d;
  logic        last_valid_q, last_valid_d;
  logic        frame_end;

  assign frame_end = (state_q == ST_HOLD) && (cnt_q == DIV_LAST);
  assign seq_match = cmd_rw_b && last_valid_q && (cmd_addr == 17'(last_addr_q + 17'd1));

  // Remember the effective address of every completed frame.
  always_comb begin
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    if (frame_end) begin
      last_addr_d  = addr_q;
      last_valid_d = 1'b1;
    end
  end

  // Address-tracking registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign seq_match = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign spi_sclk  = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: scoreboard bench for spi_cmd_master; the reference model
// builds each frame's expected byte list from the command format rules.
module tb_spi_cmd_master;

  localparam int unsigned SCLK_DIV  = 2;
  localparam int unsigned XFER_WAIT = 16;
`ifdef SPI_CMD_MASTER_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic        cmd_ready;
  logic        cmd_rw_b;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  rd_data;
  logic        done;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [2:0]  state;

  always #5 sys_clk = ~sys_clk;

  spi_cmd_master #(.SCLK_DIV(SCLK_DIV), .XFER_WAIT(XFER_WAIT)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_ready (cmd_ready),
    .cmd_rw_b  (cmd_rw_b),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .done      (done),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .state     (state)
  );

  typedef struct packed {
    logic [7:0]      nbytes;
    logic [3:0][7:0] b;
    logic [7:0]      rdv;
    logic            is_read;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned issued   = 0;
  int unsigned mon_done = 0;

  // Reference model state
  bit          m_last_valid;
  int unsigned m_last_addr;
  logic [7:0]  m_rd;

  // Slave model: read-back value presented MSB first, indexed by rise count
  logic [7:0]  slave_rb;
  logic [31:0] mon_rises;
  assign spi_miso = slave_rb[3'd7 - mon_rises[2:0]];

  // Monitor state
  bit          active = 1'b0;
  bit          prev_sclk;
  bit          ready_bad;
  bit          bad_period;
  int unsigned cyc = 0;
  int unsigned last_rise;
  logic [7:0]  mon_bytes [5];
  int unsigned byte_gap  [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event observed, required none", name);
  endtask

  task automatic predict(input bit rw, input int unsigned addr, input logic [7:0] data,
                         input logic [7:0] rb, output exp_t e);
    int unsigned a16, hi, lo;
    a16 = addr / 65536;
    hi  = (addr / 256) % 256;
    lo  = addr % 256;
    e.is_read = rw;
    e.b       = '0;
    if (!rw) begin
      e.nbytes = 8'd4;
      e.b[0]   = 8'(128 + a16);
      e.b[1]   = data;
      e.b[2]   = 8'(hi);
      e.b[3]   = 8'(lo);
      e.rdv    = m_rd;
    end else if (SEQ_EN && m_last_valid && addr == (m_last_addr + 1) % 131072) begin
      e.nbytes = 8'd2;
      e.b[0]   = 8'h20;
      e.rdv    = rb;
    end else begin
      e.nbytes = 8'd4;
      e.b[0]   = 8'(96 + a16);
      e.b[1]   = 8'(hi);
      e.b[2]   = 8'(lo);
      e.rdv    = rb;
    end
    if (rw) m_rd = rb;
    m_last_addr  = addr;
    m_last_valid = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int unsigned t;
    t = 0;
    while (!cmd_ready && t < 5000) begin
      @(negedge sys_clk);
      t++;
    end
    check(name, cmd_ready, 1);
  endtask

  task automatic issue(input bit rw, input int unsigned addr, input logic [7:0] data,
                       input logic [7:0] rb, input int unsigned busy_at);
    exp_t e;
    wait_ready("ready_before_issue");
    predict(rw, addr, data, rb, e);
    sb_q.push_back(e);
    issued++;
    slave_rb  = rb;
    cmd_rw_b  = rw;
    cmd_addr  = 17'(addr);
    cmd_data  = data;
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    cmd_rw_b  = 1'($urandom);
    cmd_addr  = 17'($urandom);
    cmd_data  = 8'($urandom);
    if (busy_at != 0) begin
      repeat (busy_at) @(negedge sys_clk);
      check("busy_ready_low", cmd_ready, 0);
      cmd_start = 1'b1;
      cmd_rw_b  = ~rw;
      cmd_addr  = 17'($urandom);
      @(negedge sys_clk);
      cmd_start = 1'b0;
    end
    wait_ready("frame_complete");
  endtask

  // Monitor: reconstruct each frame from the SPI pins and compare at done
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (reset) begin
        active = 1'b0;
      end else begin
        if (!active && !spi_cs_n) begin
          active     = 1'b1;
          mon_rises  = 0;
          prev_sclk  = spi_sclk;
          ready_bad  = 1'b0;
          bad_period = 1'b0;
          for (int i = 0; i < 5; i++) begin
            mon_bytes[i] = 8'h00;
            byte_gap[i]  = 0;
          end
        end
        if (active) begin
          if (cmd_ready) ready_bad = 1'b1;
          if (spi_sclk && !prev_sclk) begin
            if (mon_rises % 8 == 0) begin
              if (mon_rises != 0 && mon_rises < 40) byte_gap[mon_rises / 8] = cyc - last_rise;
            end else if (cyc - last_rise != 2 * SCLK_DIV) begin
              bad_period = 1'b1;
            end
            if (mon_rises < 40)
              mon_bytes[mon_rises / 8] = {mon_bytes[mon_rises / 8][6:0], spi_mosi};
            last_rise = cyc;
            mon_rises++;
          end
          prev_sclk = spi_sclk;
          if (done) begin
            active = 1'b0;
            if (sb_q.size() == 0) begin
              note_fail("unexpected_done");
            end else begin
              e = sb_q.pop_front();
              check("sclk_rises", mon_rises, 32'(e.nbytes) * 8);
              for (int i = 0; i < 4; i++)
                if (i < int'(e.nbytes)) check($sformatf("mosi_byte%0d", i), 32'(mon_bytes[i]), 32'(e.b[i]));
              for (int i = 1; i < 4; i++)
                if (i < int'(e.nbytes))
                  check($sformatf("byte_gap%0d", i), byte_gap[i],
                        (e.is_read && i == int'(e.nbytes) - 1) ? 2 * SCLK_DIV + XFER_WAIT : 3 * SCLK_DIV);
              check("bit_period", 32'(bad_period), 0);
              check("ready_low_in_frame", 32'(ready_bad), 0);
              check("rd_data", 32'(rd_data), 32'(e.rdv));
              mon_done++;
            end
          end else if (spi_cs_n) begin
            note_fail("cs_n_high_mid_frame");
            active = 1'b0;
          end
        end else if (done) begin
          note_fail("spurious_done");
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit          rw;
    int unsigned a;
    int unsigned t;
    int unsigned busy;
    reset        = 1'b1;
    cmd_start    = 1'b0;
    cmd_rw_b     = 1'b0;
    cmd_addr     = '0;
    cmd_data     = '0;
    slave_rb     = '0;
    mon_rises    = 0;
    m_last_valid = 1'b0;
    m_last_addr  = 0;
    m_rd         = 8'h00;

    // Simultaneous reset and start: reset wins
    repeat (2) @(negedge sys_clk);
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    @(negedge sys_clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_state", state, 0);
    reset = 1'b0;
    @(negedge sys_clk);

    issue(1'b0, 32'h12345, 8'hA5, 8'h00, 0);
    issue(1'b1, 32'h08000, 8'h00, 8'h5C, 0);
    issue(1'b1, 32'h08001, 8'h00, 8'($urandom), 0);
    issue(1'b0, 32'h00ABC, 8'h3C, 8'h00, 40);
    issue(1'b0, 32'h1FFFF, 8'($urandom), 8'h00, 0);
    issue(1'b1, 32'h00000, 8'h00, 8'hC3, 0);

    // Abort a write at bit 3 of its second byte
    wait_ready("ready_before_abort");
    slave_rb  = 8'h00;
    cmd_rw_b  = 1'b0;
    cmd_addr  = 17'h04321;
    cmd_data  = 8'h99;
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (mon_rises < 11 && t < 2000);
    check("abort_point_reached", 32'(mon_rises >= 11), 1);
    reset = 1'b1;
    @(negedge sys_clk);
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_state", state, 0);
    @(negedge sys_clk);
    reset        = 1'b0;
    m_last_valid = 1'b0;
    m_rd         = 8'h00;
    issue(1'b1, 32'h00001, 8'h00, 8'h96, 0);

    // Randomized frames, biased towards sequential addresses
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom);
      if ($urandom_range(0, 1) == 1 && m_last_valid) a = (m_last_addr + 1) % 131072;
      else if ($urandom_range(0, 7) == 0)            a = 32'h1FFFF;
      else                                           a = $urandom_range(0, 131071);
      busy = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 60) : 0;
      issue(rw, a, 8'($urandom), 8'($urandom), busy);
    end

    repeat (10) @(negedge sys_clk);
    check("scoreboard_empty", sb_q.size(), 0);
    check("done_count", mon_done, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog timeout");
  end

endmodule
